// File: rtl/xnor_arith_pkg.sv
// Shared types and helpers for the XNOR-approximate arithmetic family.
package xnor_arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sub_state_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

  // Approximate positions beyond the operand width have no meaning; pin them to the width.
  function automatic int clamp_approx(input int width, input int approx_bits);
    if (approx_bits > width) return width;
    if (approx_bits < 0)     return 0;
    return approx_bits;
  endfunction

endpackage

// File: rtl/xnor_full_subtractor.sv
// One-bit full-subtractor cell; APPROX selects the XNOR-approximate difference equation.
module xnor_full_subtractor #(
  parameter bit APPROX = 1'b1
) (
  input  logic input1_i,
  input  logic input2_i,
  input  logic borrow_i,
  output logic diff_o,
  output logic borrow_o
);

  logic bits_equal;

  assign bits_equal = ~(input1_i ^ input2_i);
  // Borrow is exact in both variants; only the difference bit is approximated.
  assign borrow_o   = (bits_equal & borrow_i) | (~input1_i & input2_i);

  if (APPROX) begin : g_approx
    assign diff_o = bits_equal & borrow_i;
  end else begin : g_exact
    assign diff_o = input1_i ^ input2_i ^ borrow_i;
  end

endmodule

// File: rtl/xnor_serial_subtractor.sv
// Bit-serial LSB-first approximate subtractor with valid/ready handshakes.
// Define XNOR_SUB_ERR_MON_EN to add the err_o absolute-error monitor.
module xnor_serial_subtractor
  import xnor_arith_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int APPROX_BITS = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] minuend_i,
  input  logic [WIDTH-1:0] subtrahend_i,
  input  logic             borrow_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
`ifdef XNOR_SUB_ERR_MON_EN
  ,
  output logic [WIDTH:0]   err_o
`endif
);

  localparam int APPROX_EFF = clamp_approx(WIDTH, APPROX_BITS);
  localparam int CW         = (WIDTH == DEFAULT_WIDTH) ? CNT_W : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;

  logic d_apx, bo_apx, d_ex, bo_ex;
  logic use_apx, d_bit, bout;
  logic accept, shift_en, last_shift;
  logic [WIDTH-1:0] diff_next;

  xnor_full_subtractor #(.APPROX(1'b1)) u_cell_apx (
    .input1_i (a_sr[0]),
    .input2_i (b_sr[0]),
    .borrow_i (borrow_q),
    .diff_o   (d_apx),
    .borrow_o (bo_apx)
  );

  xnor_full_subtractor #(.APPROX(1'b0)) u_cell_ex (
    .input1_i (a_sr[0]),
    .input2_i (b_sr[0]),
    .borrow_i (borrow_q),
    .diff_o   (d_ex),
    .borrow_o (bo_ex)
  );

  assign use_apx    = (int'(cnt_q) < APPROX_EFF);
  assign d_bit      = use_apx ? d_apx  : d_ex;
  assign bout       = use_apx ? bo_apx : bo_ex;
  assign diff_next  = {d_bit, diff_sr[WIDTH-1:1]};
  assign accept     = (state_q == IDLE) && valid_i;
  assign shift_en   = (state_q == SHIFT);
  assign last_shift = shift_en && (cnt_q == LAST_BIT);

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == LAST_BIT) state_d = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values, so the
  // shift chain and the borrow flop advance together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      // NOTE: the datapath registers are reset too, so an aborted operation leaves no residue.
      a_sr     <= '0;
      b_sr     <= '0;
      diff_sr  <= '0;
      borrow_q <= 1'b0;
      diff_o   <= '0;
      borrow_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_sr     <= minuend_i;
        b_sr     <= subtrahend_i;
        borrow_q <= borrow_i;
        cnt_q    <= '0;
      end else if (shift_en) begin
        a_sr     <= a_sr >> 1;
        b_sr     <= b_sr >> 1;
        diff_sr  <= diff_next;
        borrow_q <= bout;
        if (!last_shift) cnt_q <= cnt_q + 1'b1;
      end
      if (last_shift) begin
        diff_o   <= diff_next;
        borrow_o <= bout;
      end
    end
  end

`ifdef XNOR_SUB_ERR_MON_EN
  logic [WIDTH:0] exact_q, result_next;

  assign result_next = {bout, diff_next};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exact_q <= '0;
      err_o   <= '0;
    end else begin
      if (accept)
        exact_q <= {1'b0, minuend_i} - {1'b0, subtrahend_i} - {{WIDTH{1'b0}}, borrow_i};
      if (last_shift)
        err_o <= (exact_q >= result_next) ? (exact_q - result_next) : (result_next - exact_q);
    end
  end
`endif

endmodule

// File: tb/tb_xnor_serial_subtractor.sv
// Self-checking bench: four subtractors (APPROX_BITS 16, 0, 7, 99) share stimulus and are
// compared against an arithmetic reference model. Define XNOR_SUB_ERR_MON_EN to check err_o.
module tb_xnor_serial_subtractor;

  localparam int W = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i, valid_i, ready_i, borrow_i;
  logic [W-1:0] a_i, b_i;

  logic [N-1:0]        ready_w, valid_w, bor_w;
  logic [N-1:0][W-1:0] diff_w;
`ifdef XNOR_SUB_ERR_MON_EN
  logic [N-1:0][W:0]   err_w;
`endif

  int errors = 0;
  int checks = 0;

  function automatic int ab_of(input int g);
    case (g)
      0:       return 16;
      1:       return 0;
      2:       return 7;
      default: return 99;
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    xnor_serial_subtractor #(.WIDTH(W), .APPROX_BITS(ab_of(g))) u_dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .valid_i      (valid_i),
      .ready_o      (ready_w[g]),
      .minuend_i    (a_i),
      .subtrahend_i (b_i),
      .borrow_i     (borrow_i),
      .valid_o      (valid_w[g]),
      .ready_i      (ready_i),
      .diff_o       (diff_w[g]),
      .borrow_o     (bor_w[g])
`ifdef XNOR_SUB_ERR_MON_EN
      ,
      .err_o        (err_w[g])
`endif
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: per-position truth arithmetic; borrow is always the true borrow of a-b-bin.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input int approx, output logic [W-1:0] d, output logic bo,
                       output logic [W:0] e);
    int eff, bi, t, ex, r, diffv;
    eff = (approx > W) ? W : approx;
    bi  = int'(bin);
    d   = '0;
    for (int i = 0; i < W; i++) begin
      t = int'(a[i]) - int'(b[i]) - bi;
      if (i < eff) d[i] = (a[i] == b[i]) && (bi == 1);
      else         d[i] = ((t % 2) != 0);
      bi = (t < 0) ? 1 : 0;
    end
    bo = bi[0];
    ex = int'(a) - int'(b) - int'(bin);
    if (ex < 0) ex += (1 << (W + 1));
    r     = int'(bo) * (1 << W) + int'(d);
    diffv = (ex > r) ? ex - r : r - ex;
    e     = diffv[W:0];
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    @(negedge clk);
    check("ready_idle", 64'(ready_w), 64'(4'hF));
    valid_i  = 1'b1;
    a_i      = a;
    b_i      = b;
    borrow_i = bin;
    @(negedge clk);
    valid_i  = 1'b0;
    a_i      = W'($urandom);
    b_i      = W'($urandom);
    borrow_i = 1'($urandom);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input int hold, input bit chk_lat);
    logic [N-1:0][W-1:0] ed;
    logic [N-1:0]        eb;
    logic [N-1:0][W:0]   ee;
    logic [W-1:0]        td;
    logic                tb;
    logic [W:0]          te;
    int                  lat;
    for (int g = 0; g < N; g++) begin
      model(a, b, bin, ab_of(g), td, tb, te);
      ed[g] = td;
      eb[g] = tb;
      ee[g] = te;
    end
    start_op(a, b, bin);
    // Cycles counted from acceptance, the accepting cycle being the first.
    lat = 1;
    while (valid_w !== 4'hF && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("valid_done", 64'(valid_w), 64'(4'hF));
    if (chk_lat) check("latency", 64'(lat), 64'd17);
    for (int g = 0; g < N; g++) begin
      check($sformatf("diff[%0d]", g),   64'(diff_w[g]), 64'(ed[g]));
      check($sformatf("borrow[%0d]", g), 64'(bor_w[g]),  64'(eb[g]));
`ifdef XNOR_SUB_ERR_MON_EN
      check($sformatf("err[%0d]", g),    64'(err_w[g]),  64'(ee[g]));
`endif
    end
    repeat (hold) begin
      valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      check("hold_valid", 64'(valid_w), 64'(4'hF));
      check("hold_ready", 64'(ready_w), 64'd0);
      check("hold_diff",  64'(diff_w),  64'(ed));
    end
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check("release_valid",  64'(valid_w), 64'd0);
    check("release_ready",  64'(ready_w), 64'(4'hF));
    check("idle_diff_hold", 64'(diff_w),  64'(ed));
    check("idle_bor_hold",  64'(bor_w),   64'(eb));
  endtask

  initial begin
    rst_i    = 1'b1;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    borrow_i = 1'b0;
    a_i      = '0;
    b_i      = '0;
    repeat (3) @(negedge clk);
    check("rst_ready",  64'(ready_w), 64'(4'hF));
    check("rst_valid",  64'(valid_w), 64'd0);
    check("rst_diff",   64'(diff_w),  64'd0);
    check("rst_borrow", 64'(bor_w),   64'd0);
`ifdef XNOR_SUB_ERR_MON_EN
    check("rst_err",    64'(err_w),   64'd0);
`endif
    rst_i = 1'b0;

    do_op(16'hFFFF, 16'h0000, 1'b0, 0, 1'b1);
    check("plan_ffff_apx", 64'(diff_w[0]), 64'h0000);
    do_op(16'h0000, 16'h0001, 1'b0, 0, 1'b1);
    check("plan_0m1_apx", 64'(diff_w[0]), 64'hFFFE);
    do_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0);
    check("plan_bin_apx", 64'(diff_w[0]), 64'hFFFF);
    do_op(16'h1234, 16'h0235, 1'b0, 5, 1'b0);
    check("plan_exact", 64'(diff_w[1]), 64'h0FFF);

    // Abort at bit 7 of the shift sequence.
    start_op(16'hBEEF, 16'h1357, 1'b1);
    repeat (7) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("abort_ready",  64'(ready_w), 64'(4'hF));
    check("abort_valid",  64'(valid_w), 64'd0);
    check("abort_diff",   64'(diff_w),  64'd0);
    check("abort_borrow", 64'(bor_w),   64'd0);
`ifdef XNOR_SUB_ERR_MON_EN
    check("abort_err",    64'(err_w),   64'd0);
`endif
    do_op(16'h0003, 16'h0001, 1'b0, 0, 1'b1);
    check("fresh_exact", 64'(diff_w[1]), 64'h0002);

    for (int k = 0; k < 12; k++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
